// File: rtl/mux2_bus_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry output register with valid/ready handshake.
// Optional build macro ARB_FIXED_PRIO_EN: requester 0 always wins contention instead of round-robin.
module mux2_bus_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               last_grant_r;
    logic [WIDTH-1:0]   out_data_r;
    logic               out_src_r;
    logic [CNT_W-1:0]   xfer_count_r;
    logic               can_load_s;
    logic               grant_valid_s;
    logic               grant_s;
    logic               drain_s;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign out_valid  = (state_r == FULL);
    assign out_data   = out_data_r;
    assign out_src    = out_src_r;
    assign xfer_count = xfer_count_r;

    assign drain_s    = out_valid && out_ready;
    assign can_load_s = (state_r == EMPTY) || drain_s;

    // Grant selection; suppressed while reset is high so no word is accepted and then lost.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = 1'b0;
        if (can_load_s && !reset) begin
            case ({in1_valid, in0_valid})
                2'b01: begin
                    grant_valid_s = 1'b1;
                    grant_s       = 1'b0;
                end
                2'b10: begin
                    grant_valid_s = 1'b1;
                    grant_s       = 1'b1;
                end
                2'b11: begin
                    grant_valid_s = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
                    grant_s       = 1'b0;
`else
                    grant_s       = ~last_grant_r;
`endif
                end
                default: begin
                    grant_valid_s = 1'b0;
                    grant_s       = 1'b0;
                end
            endcase
        end else begin
            grant_valid_s = 1'b0;
            grant_s       = 1'b0;
        end
    end

    assign in0_ready = grant_valid_s && !grant_s;
    assign in1_ready = grant_valid_s && grant_s;

    // Next-state: a grant always fills the register, a bare drain empties it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (grant_valid_s) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FULL: begin
                if (grant_valid_s) begin
                    state_nxt_s = FULL;
                end else if (out_ready) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output word, source and arbitration history; last_grant resets to 1 so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_r   <= {WIDTH{1'b0}};
            out_src_r    <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (grant_valid_s) begin
            out_data_r   <= grant_s ? in1_data : in0_data;
            out_src_r    <= grant_s;
            last_grant_r <= grant_s;
        end
    end

    // Completed-handshake counter, wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_count_r <= {CNT_W{1'b0}};
        end else if (drain_s) begin
            xfer_count_r <= xfer_count_r + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_mux2_bus_arbiter.sv
// Directed self-checking bench for mux2_bus_arbiter (CNT_W=4 so the counter wrap is reachable).
// Honours ARB_FIXED_PRIO_EN for the contention expectations.
module tb_mux2_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in0_valid;
    logic [31:0] in0_data;
    logic        in0_ready;
    logic        in1_valid;
    logic [31:0] in1_data;
    logic        in1_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_src;
    logic        out_ready;
    logic [3:0]  xfer_count;

    int checks   = 0;
    int failures = 0;

    mux2_bus_arbiter #(.WIDTH(32), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in0_valid  (in0_valid),
        .in0_data   (in0_data),
        .in0_ready  (in0_ready),
        .in1_valid  (in1_valid),
        .in1_data   (in1_data),
        .in1_ready  (in1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
    endtask

`ifdef ARB_FIXED_PRIO_EN
    localparam logic [3:0] EXP_SRC = 4'b0000;
`else
    localparam logic [3:0] EXP_SRC = 4'b1010;
`endif

    initial begin
        logic [3:0] src_tab;
        src_tab   = EXP_SRC;
        reset     = 1'b1;
        in0_valid = 1'b0;
        in0_data  = 32'h0;
        in1_valid = 1'b0;
        in1_data  = 32'h0;
        out_ready = 1'b0;

        // Reset then idle; a pending requester must not see ready while reset is high.
        in0_valid = 1'b1;
        repeat (3) cycle();
        check_val("rst_in0_ready", {63'b0, in0_ready}, 64'd0);
        check_val("rst_out_valid", {63'b0, out_valid}, 64'd0);
        reset     = 1'b0;
        in0_valid = 1'b0;
        cycle();
        check_val("idle_out_valid", {63'b0, out_valid}, 64'd0);
        check_val("idle_out_data", {32'b0, out_data}, 64'd0);
        check_val("idle_count", {60'b0, xfer_count}, 64'd0);
        check_val("idle_rdy", {62'b0, in1_ready, in0_ready}, 64'd0);

        // Single requester streaming.
        out_ready = 1'b1;
        in0_valid = 1'b1;
        in0_data  = 32'hA5A5A5A5;
        #1 check_val("s_rdy0_a", {63'b0, in0_ready}, 64'd1);
        cycle();
        check_val("s_data_a", {32'b0, out_data}, 64'hA5A5A5A5);
        check_val("s_valid_a", {63'b0, out_valid}, 64'd1);
        in0_data = 32'h00000001;
        #1 check_val("s_rdy0_b", {63'b0, in0_ready}, 64'd1);
        cycle();
        check_val("s_data_b", {32'b0, out_data}, 64'h1);
        check_val("s_src_b", {63'b0, out_src}, 64'd0);
        in0_valid = 1'b0;
        cycle();
        check_val("s_count", {60'b0, xfer_count}, 64'd2);
        check_val("s_drained", {63'b0, out_valid}, 64'd0);
        check_val("s_hold_data", {32'b0, out_data}, 64'h1);

        // Contention with both requesters valid continuously.
        do_reset();
        in0_valid = 1'b1;
        in0_data  = 32'h11111111;
        in1_valid = 1'b1;
        in1_data  = 32'h22222222;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check_val("c_rdy1", {63'b0, in1_ready}, {63'b0, src_tab[i]});
            cycle();
            check_val("c_src", {63'b0, out_src}, {63'b0, src_tab[i]});
            check_val("c_data", {32'b0, out_data}, src_tab[i] ? 64'h22222222 : 64'h11111111);
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;

        // Backpressure, then drain and load on the same edge.
        do_reset();
        out_ready = 1'b0;
        in0_valid = 1'b1;
        in0_data  = 32'hDEADBEEF;
        cycle();
        in0_valid = 1'b0;
        in1_valid = 1'b1;
        in1_data  = 32'h33333333;
        for (int i = 0; i < 5; i++) begin
            #1 check_val("bp_rdy1", {63'b0, in1_ready}, 64'd0);
            cycle();
            check_val("bp_data", {32'b0, out_data}, 64'hDEADBEEF);
        end
        check_val("bp_count0", {60'b0, xfer_count}, 64'd0);
        out_ready = 1'b1;
        #1 check_val("bp_rdy1_go", {63'b0, in1_ready}, 64'd1);
        cycle();
        check_val("bp_new_data", {32'b0, out_data}, 64'h33333333);
        check_val("bp_new_src", {63'b0, out_src}, 64'd1);
        check_val("bp_valid", {63'b0, out_valid}, 64'd1);
        check_val("bp_count1", {60'b0, xfer_count}, 64'd1);
        in1_valid = 1'b0;

        // Counter wrap: first edge loads, each later edge completes one handshake.
        do_reset();
        out_ready = 1'b1;
        in0_valid = 1'b1;
        in0_data  = 32'h00000042;
        repeat (17) cycle();
        check_val("wrap_16", {60'b0, xfer_count}, 64'd0);
        in0_valid = 1'b0;
        cycle();
        check_val("wrap_17", {60'b0, xfer_count}, 64'd1);

        // Asynchronous reset mid-operation, then first-grant after release.
        do_reset();
        out_ready = 1'b0;
        in0_valid = 1'b1;
        in0_data  = 32'hCAFEF00D;
        cycle();
        check_val("mr_loaded", {32'b0, out_data}, 64'hCAFEF00D);
        in0_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_val("mr_valid", {63'b0, out_valid}, 64'd0);
        check_val("mr_data", {32'b0, out_data}, 64'd0);
        #1 reset = 1'b0;
        in0_valid = 1'b1;
        in0_data  = 32'h44444444;
        in1_valid = 1'b1;
        in1_data  = 32'h55555555;
        out_ready = 1'b1;
        #1;
        check_val("mr_rdy0", {63'b0, in0_ready}, 64'd1);
        check_val("mr_rdy1", {63'b0, in1_ready}, 64'd0);
        cycle();
        check_val("mr_first_src", {63'b0, out_src}, 64'd0);
        check_val("mr_first_data", {32'b0, out_data}, 64'h44444444);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
